// File: rtl/divider_pkg.sv
// Shared widths, FSM encoding and constants for the sequential 16/8 restoring divider.
package divider_pkg;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int CW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [DW-1:0] DIV0_Q = {DW{1'b1}};

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and trial-subtract the divisor.
module div_restoring_step
  import divider_pkg::*;
(
  input  logic [VW-1:0] rem,
  input  logic          q_msb,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_next,
  output logic          qbit
);

  logic [VW:0] rem_s;
  logic [VW:0] trial_s;

  // Trial subtract in VW+1 bits; the top bit is the borrow that decides restore vs keep.
  always_comb begin
    rem_s   = {rem, q_msb};
    trial_s = rem_s - {1'b0, divisor};
    if (trial_s[VW] == 1'b0) begin
      rem_next = trial_s[VW-1:0];
      qbit     = 1'b1;
    end else begin
      rem_next = rem_s[VW-1:0];
      qbit     = 1'b0;
    end
  end

endmodule

// File: rtl/divider16by8_seq.sv
// Sequential restoring divider with valid/ready on both sides; one division in flight.
module divider16by8_seq
  import divider_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  state_e        state_r;
  state_e        state_next_s;
  logic [CW-1:0] cnt_r;
  logic [DW-1:0] q_r;
  logic [VW-1:0] rem_r;
  logic [VW-1:0] div_r;
  logic [DW-1:0] quotient_r;
  logic [VW-1:0] remainder_r;
  logic          dbz_r;
  logic          accept_s;
  logic          div0_s;
  logic          last_step_s;
  logic [VW-1:0] rem_next_s;
  logic          qbit_s;

  assign accept_s    = in_valid && (state_r == IDLE);
  assign div0_s      = (divisor == {VW{1'b0}});
  assign last_step_s = (cnt_r == CW'(1));

  div_restoring_step u_step (
    .rem      (rem_r),
    .q_msb    (q_r[DW-1]),
    .divisor  (div_r),
    .rem_next (rem_next_s),
    .qbit     (qbit_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a zero divisor skips the iteration phase entirely.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = div0_s ? DONE : BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (last_step_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      BUSY:    in_ready  = 1'b0;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: operand capture, one step per BUSY cycle, result registers loaded on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CW{1'b0}};
      q_r         <= {DW{1'b0}};
      rem_r       <= {VW{1'b0}};
      div_r       <= {VW{1'b0}};
      quotient_r  <= {DW{1'b0}};
      remainder_r <= {VW{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && div0_s) begin
            quotient_r  <= DIV0_Q;
            remainder_r <= dividend[VW-1:0];
            dbz_r       <= 1'b1;
            cnt_r       <= {CW{1'b0}};
          end else if (accept_s) begin
            q_r   <= dividend;
            div_r <= divisor;
            rem_r <= {VW{1'b0}};
            cnt_r <= CW'(DW);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        BUSY: begin
          q_r   <= {q_r[DW-2:0], qbit_s};
          rem_r <= rem_next_s;
          cnt_r <= cnt_r - CW'(1);
          if (last_step_s) begin
            quotient_r  <= {q_r[DW-2:0], qbit_s};
            remainder_r <= rem_next_s;
            dbz_r       <= 1'b0;
          end else begin
            dbz_r <= dbz_r;
          end
        end
        DONE:    cnt_r <= cnt_r;
        default: cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_divider16by8_seq.sv
// Self-checking bench for divider16by8_seq: vector table, corner sequences, random sweep with scoreboard.
module tb_divider16by8_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] p;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  vec_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  divider16by8_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [15:0] p, input logic [7:0] b);
    vec_t e;
    e.p = p;
    e.b = b;
    if (b == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = p[7:0];
      e.dbz = 1'b1;
    end else begin
      e.q   = 16'(int'(p) / int'(b));
      e.r   = 8'(int'(p) % int'(b));
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Issue one operation, wait for its result, optionally stall the consumer, then retire it.
  task automatic run_op(input vec_t e, input bit chk_lat, input int hold, input bit poke);
    vec_t got;
    int   lat;
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    dividend  = e.p;
    divisor   = e.b;
    @(posedge clk);
    sb_q.push_back(e);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (poke) begin
        in_valid = lat[0];
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: out_valid got 0 expected 1");
      void'(sb_q.pop_front());
      return;
    end
    if (chk_lat) check("latency", lat, (e.b == 8'd0) ? 32'd1 : 32'd17);
    for (int k = 0; k < hold; k++) begin
      check("hold_q", {16'd0, quotient}, {16'd0, sb_q[0].q});
      check("hold_r", {24'd0, remainder}, {24'd0, sb_q[0].r});
      check("hold_dbz", {31'd0, div_by_zero}, {31'd0, sb_q[0].dbz});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: got empty queue expected entry");
      return;
    end
    got = sb_q.pop_front();
    check("quotient", {16'd0, quotient}, {16'd0, got.q});
    check("remainder", {24'd0, remainder}, {24'd0, got.r});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, got.dbz});
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retire_out_valid", {31'd0, out_valid}, 32'd0);
    check("retire_in_ready", {31'd0, in_ready}, 32'd1);
    check("retire_q_kept", {16'd0, quotient}, {16'd0, got.q});
  endtask

  vec_t tbl[10];

  initial begin
    vec_t e;
    logic [7:0] a;
    logic [7:0] b;

    tbl[0] = '{16'h0C35, 8'h19, 16'h007D, 8'h00, 1'b0};
    tbl[1] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0};
    tbl[2] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0};
    tbl[3] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1};
    tbl[4] = '{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0};
    tbl[5] = '{16'h0042, 8'h80, 16'h0000, 8'h42, 1'b0};
    tbl[6] = '{16'h7FFF, 8'h01, 16'h7FFF, 8'h00, 1'b0};
    tbl[7] = '{16'h00FF, 8'hFF, 16'h0001, 8'h00, 1'b0};
    tbl[8] = '{16'hABCD, 8'h10, 16'h0ABC, 8'h0D, 1'b0};
    tbl[9] = '{16'd1000, 8'd3, 16'd333, 8'd1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'd0;
    divisor   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_op(tbl[i], 1'b1, 0, 1'b0);

    // Backpressure with in_valid pokes during BUSY.
    run_op(model(16'd5000, 8'd9), 1'b1, 10, 1'b1);
    run_op(model(16'h0BAD, 8'd0), 1'b1, 10, 1'b0);

    // Abort mid-BUSY: the in-flight result must vanish immediately.
    in_valid = 1'b1;
    dividend = 16'h5555;
    divisor  = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_quotient", {16'd0, quotient}, 32'd0);
    check("abort_remainder", {24'd0, remainder}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op('{16'd100, 8'd7, 16'd14, 8'd2, 1'b0}, 1'b1, 0, 1'b0);

    // Exact-product recovery sweep.
    for (int i = 0; i < 1500; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      e = model(16'(a) * 16'(b), b);
      if (e.q !== {8'd0, a} || e.r !== 8'd0) begin
        n_err++;
        $display("FAIL model_product: a %0d b %0d", a, b);
      end
      e.q = {8'd0, a};
      e.r = 8'd0;
      run_op(e, 1'b0, 0, 1'b0);
    end

    // Random dividend/divisor against the reference model.
    for (int i = 0; i < 500; i++) begin
      run_op(model(16'($urandom), 8'($urandom)), 1'b0, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
